// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_engine_pkg
//   Shared constants for the memory copy engine: FSM state encodings and
//   the size of the word-addressed data memory.
//   No ports; imported by mem_copy_engine and copy_range_check.
package mem_copy_engine_pkg;

  // Number of addressable words in the data memory (addr[9:0] decoded).
  localparam int unsigned MEM_WORDS = 1024;

  // Copy FSM state encoding (3-bit, fixed values).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_copy_engine_copy_range_check.sv
// copy_range_check
//   Combinational validation of a latched copy request. Flags requests
//   whose source or destination run past the end of memory, and forward
//   overlaps (src < dst < src+len) that a forward-only copy would corrupt.
// Ports:
//   src     in  32     first source word index
//   dst     in  32     first destination word index
//   len     in  LEN_W  number of words
//   reject  out 1      request must be refused
module copy_range_check
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned MEM_WORDS_P = MEM_WORDS,
  parameter int unsigned LEN_W       = 11
) (
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             reject
);

  // Sums are formed at LEN_W+32 bits so neither end address can wrap.
  localparam int unsigned SW = LEN_W + 32;

  logic [SW-1:0] src_w;
  logic [SW-1:0] dst_w;
  logic [SW-1:0] len_w;
  logic [SW-1:0] limit_w;
  logic [SW-1:0] src_end;
  logic [SW-1:0] dst_end;

  // Bounds and forward-overlap evaluation.
  always_comb begin
    src_w   = {{LEN_W{1'b0}}, src};
    dst_w   = {{LEN_W{1'b0}}, dst};
    len_w   = {32'd0, len};
    limit_w = SW'(MEM_WORDS_P);
    src_end = src_w + len_w;
    dst_end = dst_w + len_w;
    reject  = (src_end > limit_w) ||
              (dst_end > limit_w) ||
              ((src_w < dst_w) && (dst_w < src_end));
  end

endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Bus initiator copying a block of words from a source region to a
//   destination region of the word-addressed data memory, one word every
//   two cycles (READ then WRITE). Requests are validated for one cycle
//   (CHECK) before any memory access; rejected requests pulse err.
// Ports:
//   clock     in  1      system clock, state updates on posedge
//   reset     in  1      asynchronous active-low reset
//   start     in  1      request pulse, sampled only in IDLE
//   src_addr  in  32     first source word index
//   dst_addr  in  32     first destination word index
//   len       in  LEN_W  words to copy
//   busy      out 1      request in progress (CHECK..FIN)
//   done      out 1      one-cycle completion pulse
//   err       out 1      one-cycle reject pulse
//   mem_ren   out 1      memory read enable
//   mem_wen   out 1      memory write enable
//   mem_addr  out 32     memory word address
//   mem_din   out 32     memory write data
//   mem_dout  in  32     memory read data (combinational while ren=1)
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned MEM_WORDS_P = MEM_WORDS,
  parameter int unsigned LEN_W       = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout
);

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      buf_q, buf_d;
  logic             err_q, err_d;
  logic             ren_q, ren_d;
  logic             wen_q, wen_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic             reject_s;

  copy_range_check #(
    .MEM_WORDS_P (MEM_WORDS_P),
    .LEN_W       (LEN_W)
  ) u_range_check (
    .src    (src_q),
    .dst    (dst_q),
    .len    (len_q),
    .reject (reject_s)
  );

  // Next-state, datapath and next memory-port values.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    addr_d  = 32'd0;
    din_d   = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        // err is registered so it lands in the IDLE cycle, where busy is 0.
        if (reject_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (len_q == {LEN_W{1'b0}}) begin
          state_d = ST_FIN;
        end else begin
          cnt_d   = {LEN_W{1'b0}};
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        buf_d   = mem_dout;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        cnt_d = cnt_q + LEN_W'(1);
        if ((cnt_q + LEN_W'(1)) == len_q) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Port values are computed for the state being entered and registered,
    // so the memory sees stable, glitch-free strobes across the negedge.
    case (state_d)
      ST_READ: begin
        ren_d  = 1'b1;
        addr_d = src_q + 32'(cnt_d);
      end
      ST_WRITE: begin
        wen_d  = 1'b1;
        addr_d = dst_q + 32'(cnt_d);
        din_d  = buf_d;
      end
      default: begin
        ren_d  = 1'b0;
        wen_d  = 1'b0;
      end
    endcase
  end

  // State, request latch, counter, buffer and registered port outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      src_q   <= 32'd0;
      dst_q   <= 32'd0;
      len_q   <= {LEN_W{1'b0}};
      cnt_q   <= {LEN_W{1'b0}};
      buf_q   <= 32'd0;
      err_q   <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      din_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign err      = err_q;
  assign mem_ren  = ren_q;
  assign mem_wen  = wen_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine
//   Directed bench for mem_copy_engine with a behavioural memory and a
//   per-cycle expected-output queue built from the request rules.
module tb_mem_copy_engine;

  localparam int LEN_W = 11;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] din;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_addr = 32'd0;
  logic [31:0]      dst_addr = 32'd0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err, mem_ren, mem_wen;
  logic [31:0]      mem_addr, mem_din, mem_dout;

  logic [31:0] mem       [0:1023];
  logic [31:0] model_mem [0:1023];
  exp_t        exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;

  mem_copy_engine #(.LEN_W(LEN_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  assign mem_dout = mem_ren ? mem[mem_addr[9:0]] : 32'h0;

  function automatic exp_t mk(input logic b, input logic d, input logic e,
                              input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] di);
    exp_t x;
    x.busy = b; x.done = d; x.err = e; x.ren = r; x.wen = w;
    x.addr = a; x.din = di;
    return x;
  endfunction

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one accepted start, from the rules:
  // CHECK cycle, then either an err cycle or N read/write pairs and a done cycle.
  task automatic model_request(input logic [31:0] s, input logic [31:0] d, input int n);
    longint ls = longint'(s);
    longint ld = longint'(d);
    longint ln = longint'(n);
    bit rej;
    rej = (ls + ln > 1024) || (ld + ln > 1024) || ((ls < ld) && (ld < ls + ln));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    if (rej) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0));
    end else begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s + 32'(k), 32'd0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, d + 32'(k),
                           model_mem[10'(s + 32'(k))]));
      end
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    end
  endtask

  // Per-cycle compare on the negedge; also the memory commit point.
  task automatic compare_loop();
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      act = mk(busy, done, err, mem_ren, mem_wen, mem_addr, mem_din);
      check("cycle_outputs", 69'(act), 69'(e));
      check("ren_wen_excl", 69'(mem_ren & mem_wen), 69'd0);
      if (done) done_cyc = cyc;
      if (mem_wen) mem[mem_addr[9:0]] = mem_din;
      if (e.wen) model_mem[e.addr[9:0]] = e.din;
    end
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n);
    @(posedge clock); #1;
    start = 1'b1; src_addr = s; dst_addr = d; len = LEN_W'(n);
    start_cyc = cyc;
    model_request(s, d, n);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clock);
      k++;
    end
    check(name, 69'(exp_q.size() == 0), 69'd1);
    @(posedge clock); #1;
  endtask

  task automatic check_image(input string name);
    int bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== model_mem[i]) bad++;
    end
    check(name, 69'(bad), 69'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]       = 32'hC0DE0000 | 32'(i);
      model_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    mem[10] = 32'hA0A0A0A0; model_mem[10] = 32'hA0A0A0A0;
    mem[11] = 32'hB1B1B1B1; model_mem[11] = 32'hB1B1B1B1;
    mem[12] = 32'hC2C2C2C2; model_mem[12] = 32'hC2C2C2C2;
    mem[13] = 32'hD3D3D3D3; model_mem[13] = 32'hD3D3D3D3;

    fork
      compare_loop();
    join_none

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs",
          69'(mk(busy, done, err, mem_ren, mem_wen, mem_addr, mem_din)), 69'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Basic 4-word copy.
    do_start(32'd10, 32'd100, 4);
    wait_drain("copy4_drain");
    check("copy4_done_latency", 69'(done_cyc - start_cyc), 69'd10);
    check("copy4_dst0", 69'(mem[100]), 69'h0A0A0A0A0);
    check("copy4_dst1", 69'(mem[101]), 69'h0B1B1B1B1);
    check("copy4_dst2", 69'(mem[102]), 69'h0C2C2C2C2);
    check("copy4_dst3", 69'(mem[103]), 69'h0D3D3D3D3);
    check("copy4_src_kept", 69'(mem[13]), 69'h0D3D3D3D3);
    check_image("copy4_image");

    // Zero-length request.
    do_start(32'd5, 32'd6, 0);
    wait_drain("len0_drain");
    check("len0_done_latency", 69'(done_cyc - start_cyc), 69'd2);
    check_image("len0_image");

    // Out-of-range request.
    do_start(32'd1020, 32'd0, 8);
    wait_drain("oob_drain");
    check("oob_mem0_kept", 69'(mem[0]), 69'h0C0DE0000);
    check_image("oob_image");

    // Forward overlap rejected, reverse overlap accepted.
    do_start(32'd20, 32'd22, 4);
    wait_drain("ovl_fwd_drain");
    do_start(32'd22, 32'd20, 4);
    wait_drain("ovl_rev_drain");
    check("ovl_rev_20", 69'(mem[20]), 69'h0C0DE0016);
    check("ovl_rev_21", 69'(mem[21]), 69'h0C0DE0017);
    check("ovl_rev_22", 69'(mem[22]), 69'h0C0DE0018);
    check("ovl_rev_23", 69'(mem[23]), 69'h0C0DE0019);
    check_image("ovl_image");

    // Second start while busy is ignored.
    do_start(32'd30, 32'd40, 3);
    @(posedge clock); #1;
    start = 1'b1; src_addr = 32'd600; dst_addr = 32'd700; len = LEN_W'(3);
    @(posedge clock); #1;
    start = 1'b0;
    wait_drain("ignore_drain");
    check("ignore_dst40", 69'(mem[40]), 69'h0C0DE001E);
    check("ignore_dst42", 69'(mem[42]), 69'h0C0DE0020);
    check("ignore_700_kept", 69'(mem[700]), 69'h0C0DE02BC);
    check_image("ignore_image");

    // Reset during WRITE of word 2 of an 8-word copy.
    do_start(32'd200, 32'd300, 8);
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("rst_ren_wen_drop", 69'({mem_ren, mem_wen}), 69'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    check("rst_dst0", 69'(mem[300]), 69'h0C0DE00C8);
    check("rst_dst1", 69'(mem[301]), 69'h0C0DE00C9);
    check("rst_dst2_kept", 69'(mem[302]), 69'h0C0DE012E);
    check_image("rst_image");
    do_start(32'd400, 32'd500, 2);
    wait_drain("post_rst_drain");
    check("post_rst_dst0", 69'(mem[500]), 69'h0C0DE0190);
    check("post_rst_dst1", 69'(mem[501]), 69'h0C0DE0191);
    check_image("post_rst_image");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator that drives the word-addressed data memory port (ren, wen, addr, din, dout) to copy a block of words from a source region to a destination region.
- Used for program/data staging and testbench-free memory setup alongside the single-cycle datapath.
- The datapath is stalled externally while the engine is busy; memory port muxing is outside this block.
- Addresses are word indices: memory decodes addr[9:0], and addr[31:10] must be zero.

Parameters:
- MEM_WORDS, 1024: number of addressable words; bounds check limit.
- LEN_W, 11: width of the length field; must hold 0..MEM_WORDS.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  32  first source word index.
- dst_addr  in  32  first destination word index.
- len  in  LEN_W  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse when a request is rejected.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_addr  out  32  memory word address.
- mem_din  out  32  write data to memory.
- mem_dout  in  32  read data from memory; valid combinationally while ren=1, wen=0.

Behaviour:
- Reset (async, any time including mid-copy):
  - state=IDLE; busy, done, err, mem_ren, mem_wen = 0; mem_addr=0; mem_din=0; counter and buffer cleared.
  - A partial copy is abandoned. Words already written stay written.
- FSM states: IDLE, CHECK, READ, WRITE, FIN.
- IDLE:
  - On start=1, latch src_addr, dst_addr and len; go to CHECK.
  - start in any other state is ignored; no queuing.
- CHECK (1 cycle, no memory access):
  - Reject if src_addr+len > MEM_WORDS, or dst_addr+len > MEM_WORDS, or the ranges overlap with src < dst < src+len. The third rule exists because the copy runs forward only.
  - On reject: pulse err for one cycle and return to IDLE.
  - len=0: go to FIN.
  - Otherwise: clear word counter i=0 and go to READ.
- READ:
  - Drive mem_ren=1, mem_wen=0, mem_addr=src+i, mem_din=0.
  - At posedge, capture mem_dout into the data buffer; go to WRITE.
- WRITE:
  - Drive mem_ren=0, mem_wen=1, mem_addr=dst+i, mem_din=buffer.
  - Memory commits on the negedge inside this cycle.
  - At posedge, i=i+1. If i+1==len go to FIN, else go to READ.
- FIN: pulse done for one cycle; go to IDLE.
- Timing:
  - Latency is 2 cycles per word.
  - Total for len=N>0: busy high for 1+2N+1 cycles.
- Port rules:
  - mem_ren and mem_wen are never high together.
  - Both are 0 in IDLE, CHECK and FIN.
  - Outputs are registered or decoded from state only, so they are glitch-free relative to the negedge write.
- Arithmetic:
  - Address sums use 32-bit unsigned arithmetic.
  - Bounds checks are done at LEN_W+32 width so they cannot wrap.
  - mem_addr[31:10] is always 0 for any accepted request.
- Simultaneity: done and err never pulse in the same cycle; busy is 0 in the cycle err pulses.

Decomposition:
- Shared constants header (alongside the existing ALU/opcode constants) holds:
  - state encodings: IDLE=0, CHECK=1, READ=2, WRITE=3, FIN=4, 3-bit;
  - MEM_WORDS.
- One sub-module is natural: copy_range_check. It is combinational over the latched src, dst and len and produces a reject flag, keeping the FSM file free of the bounds and overlap arithmetic.

Test Plan:
- Preload mem[10..13]=A,B,C,D; start with src=10, dst=100, len=4:
  - mem[100..103]=A,B,C,D;
  - done pulses exactly 10 cycles after start;
  - mem[10..13] unchanged.
- len=0, src=5, dst=6:
  - no ren/wen activity;
  - done pulses 2 cycles after start.
- src=1020, dst=0, len=8: err pulses; busy is 0 in the err cycle; no memory access; memory unchanged.
- Overlap src=20, dst=22, len=4: err. Reverse case src=22, dst=20, len=4 is accepted and mem[20..23] gets the old mem[22..25].
- Assert reset low during the WRITE state of word 2 of an 8-word copy:
  - ren/wen drop to 0 immediately;
  - mem[dst+0], mem[dst+1] written, mem[dst+2] onward unchanged;
  - a new start after reset release completes normally.
- Pulse start again while busy with different args: ignored; the original copy completes with its original arguments. Throughout, an assertion checks that ren and wen are never both high.
